branch_history_table: RTL and testbench
=======================================

// Module: branch_history_table
// PURPOSE
//  Dynamic direction predictor for the RV32I front end: per-entry 2-bit saturating counters, indexed by PC.
//  Upstream of branch_predictor: it supplies predict_taken, which replaces the static sign-of-immediate guess.
//  Downstream of branch_evaluator: it consumes the resolved branch_taken outcome to train the counters.
//  Includes a sweep-clear FSM, entered on reset and on request.
// PARAMETERS
//  XLEN   32  PC width
//  IDX_W  6   index bits; DEPTH = 2**IDX_W = 64 entries; index = pc[IDX_W+1:2]
// PORTS
//  clk             in   1     clock; all state changes on rising edge
//  reset_n         in   1     reset; asynchronous, active-low
//  clear_req       in   1     pulse; restart the sweep-clear of all entries
//  ready           out  1     1 = table initialised; lookups and updates are honoured
//  lookup_valid    in   1     lookup request this cycle
//  lookup_pc       in   XLEN  PC of the instruction being fetched
//  predict_valid   out  1     registered copy of lookup_valid
//  predict_taken   out  1     registered prediction for the previous cycle's lookup_pc
//  update_valid    in   1     resolved conditional branch; caller never asserts it for jumps
//  update_pc       in   XLEN  PC of the resolved branch
//  update_taken    in   1     actual outcome (branch_evaluator branch_taken)
//  update_mispred  in   1     prediction made for this branch was wrong (stats only)
//  stat_updates    out  32    accepted updates (BHT_STATS_EN)
//  stat_mispreds   out  32    accepted updates with update_mispred=1 (BHT_STATS_EN)
// BEHAVIOUR
//  Reset values
//   - state=INIT, clr_idx=0, ready=0, predict_valid=0, predict_taken=0, stats=0.
//   - Counter array is not reset; the sweep initialises it.
//  FSM
//   - INIT: write WNT (2'b01) to entry clr_idx, clr_idx++; after entry DEPTH-1 -> READY.
//   - INIT therefore lasts exactly DEPTH cycles, then ready=1 on the next edge.
//   - READY: clear_req=1 -> INIT with clr_idx=0; ready falls on the following cycle.
//   - clear_req while already in INIT restarts the sweep at index 0.
//   - reset_n low at any time aborts the operation in progress and returns to the reset values.
//  Counter encoding and update
//   - Encoding: 00 SNT, 01 WNT, 10 WT, 11 ST; prediction = ctr[1].
//   - Update when update_valid & ready: taken -> ctr+1 saturating at 11; not taken -> ctr-1 saturating at 00.
//   - Updates while ready=0 are dropped and are not counted in the stats.
//  Lookup (latency 1)
//   - predict_valid(N+1) = lookup_valid(N).
//   - predict_taken(N+1) = ctr[idx(lookup_pc(N))][1] if ready at N, else 0.
//   - predict_taken holds its value when lookup_valid=0.
//  Simultaneous events
//   - Lookup and update to the same index in one cycle: write-first; the prediction uses the post-update counter.
//   - Different PCs with equal index alias and share an entry, by design.
//  Stats arithmetic
//   - 32-bit counters saturate at 32'hFFFF_FFFF, with no wrap.
// CONFIGURATION
//  BHT_STATS_EN defined: stat_updates and stat_mispreds count as specified above.
//  BHT_STATS_EN undefined:
//   - Counter logic is not built; both ports stay present and are tied to 0.
//   - update_mispred is ignored.
// STRUCTURE
//  bht_pkg
//   - typedef enum logic [1:0] {SNT, WNT, WT, ST} bht_ctr_t.
//   - typedef enum logic {BHT_INIT, BHT_READY} bht_state_t.
//   - localparam bht_ctr_t BHT_CTR_INIT = WNT.
//   - function bht_next_ctr(bht_ctr_t c, logic taken).
//  No sub-module; the FSM, array and stats live in this module.
// TESTING (IDX_W=6)
//  1. reset_n low 2 cycles, then high -> ready=0 for 64 cycles, 1 after; then lookup 0x0C -> predict_valid=1, predict_taken=0.
//  2. Training: 2 taken updates at 0x0C, then lookup 0x0C -> taken=1; lookup 0x10 -> taken=0.
//  3. Saturation: 3 taken then 1 not-taken at 0x0C -> taken=1 (WT); another not-taken -> taken=0 (WNT).
//  4. Aliasing and bypass
//   - Train 0x0C to ST; lookup 0x10C (index 3) -> taken=1.
//   - Set 0x0C to WNT; same-cycle update taken + lookup 0x0C -> taken=1.
//  5. Clear: clear_req in READY -> ready=0 for 64 cycles, an update during INIT is ignored, then lookup 0x0C -> taken=0.
//  6. BHT_STATS_EN: 5 updates, 2 with update_mispred -> stat_updates=5, stat_mispreds=2; reset mid-count -> 0.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table.
// Counter encoding, FSM states and the saturating counter step.
package bht_pkg;

    localparam int BHT_XLEN  = 32;
    localparam int BHT_IDX_W = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    typedef enum logic {
        BHT_INIT  = 1'b0,
        BHT_READY = 1'b1
    } bht_state_t;

    localparam bht_ctr_t BHT_CTR_INIT = WNT;

    function automatic bht_ctr_t bht_next_ctr(
        input bht_ctr_t c,
        input logic     taken
    );
        bht_ctr_t n;
        n = c;
        unique case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// 2-bit saturating-counter direction predictor indexed by pc[IDX_W+1:2].
// Ports: clk, reset_n (async low), clear_req, ready; lookup_valid/pc ->
// predict_valid/taken (1-cycle latency); update_valid/pc/taken/mispred
// trains the table; stat_updates/stat_mispreds are live only when
// BHT_STATS_EN is defined, otherwise tied to 0.
module branch_history_table
    import bht_pkg::*;
#(
    parameter int XLEN  = BHT_XLEN,
    parameter int IDX_W = BHT_IDX_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear_req,
    output logic            ready,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            predict_valid,
    output logic            predict_taken,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic            update_mispred,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispreds
);

    localparam int DEPTH = 1 << IDX_W;

    bht_state_t       state;
    bht_state_t       state_nxt;
    logic [IDX_W-1:0] clr_idx;
    bht_ctr_t         ctr_mem [DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic             upd_en;
    bht_ctr_t         upd_cur;
    bht_ctr_t         upd_nxt;
    bht_ctr_t         lk_cur;

    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign up_idx  = update_pc[IDX_W+1:2];
    assign upd_en  = update_valid & ready;
    assign upd_cur = ctr_mem[up_idx];
    assign upd_nxt = bht_next_ctr(upd_cur, update_taken);

    // Write-first: a same-cycle update to the looked-up entry is visible.
    assign lk_cur = (upd_en && (up_idx == lk_idx)) ? upd_nxt
                                                   : ctr_mem[lk_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= BHT_INIT;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (clear_req)
                clr_idx <= '0;
            else if (state == BHT_INIT)
                clr_idx <= clr_idx + IDX_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BHT_INIT: begin
                if (!clear_req && (clr_idx == IDX_W'(DEPTH - 1)))
                    state_nxt = BHT_READY;
            end
            BHT_READY: begin
                if (clear_req)
                    state_nxt = BHT_INIT;
            end
            default: state_nxt = BHT_INIT;
        endcase
    end

    always_comb begin
        ready = (state == BHT_READY);
    end

    // The array carries no reset; the sweep gives it defined contents.
    always_ff @(posedge clk) begin
        if (state == BHT_INIT)
            ctr_mem[clr_idx] <= BHT_CTR_INIT;
        else if (upd_en)
            ctr_mem[up_idx] <= upd_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            predict_valid <= 1'b0;
            predict_taken <= 1'b0;
        end else begin
            predict_valid <= lookup_valid;
            if (lookup_valid)
                predict_taken <= ready & lk_cur[1];
        end
    end

`ifdef BHT_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_updates  <= '0;
            stat_mispreds <= '0;
        end else if (upd_en) begin
            if (stat_updates != 32'hFFFF_FFFF)
                stat_updates <= stat_updates + 32'd1;
            if (update_mispred && (stat_mispreds != 32'hFFFF_FFFF))
                stat_mispreds <= stat_mispreds + 32'd1;
        end
    end
`else
    logic unused_mispred;
    assign unused_mispred = update_mispred;
    assign stat_updates   = '0;
    assign stat_mispreds  = '0;
`endif

    logic unused_pc;
    assign unused_pc = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                         update_pc[XLEN-1:IDX_W+2], update_pc[1:0]};

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table: directed vectors push
// expected predictions, a negedge monitor pops and compares them.
module tb_branch_history_table;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear_req;
    logic        ready;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        predict_valid;
    logic        predict_taken;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_mispred;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispreds;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    branch_history_table dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear_req      (clear_req),
        .ready          (ready),
        .lookup_valid   (lookup_valid),
        .lookup_pc      (lookup_pc),
        .predict_valid  (predict_valid),
        .predict_taken  (predict_taken),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_mispred (update_mispred),
        .stat_updates   (stat_updates),
        .stat_mispreds  (stat_mispreds)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Monitor: every presented prediction must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && predict_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL predict_unexpected: taken=%0b, none expected",
                         predict_taken);
            end else begin
                logic e;
                e = exp_q.pop_front();
                if (predict_taken !== e) begin
                    errors++;
                    $display("FAIL predict_taken: got %0b want %0b",
                             predict_taken, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        exp_q.push_back(exp);
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic tk,
                          input logic mis);
        update_valid   = 1'b1;
        update_pc      = pc;
        update_taken   = tk;
        update_mispred = mis;
        tick();
        update_valid   = 1'b0;
        update_mispred = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        tick();
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] exp_u;
        logic [31:0] exp_m;

        reset_n        = 1'b0;
        clear_req      = 1'b0;
        lookup_valid   = 1'b0;
        lookup_pc      = '0;
        update_valid   = 1'b0;
        update_pc      = '0;
        update_taken   = 1'b0;
        update_mispred = 1'b0;
        tick();
        tick();

        // 1. reset values, sweep length, first lookup
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_pvalid", 32'(predict_valid), 32'd0);
        check("rst_ptaken", 32'(predict_taken), 32'd0);
        check("rst_stat_upd", stat_updates, 32'd0);
        check("rst_stat_mis", stat_mispreds, 32'd0);
        reset_n = 1'b1;
        wait_ready(n);
        check("init_cycles", 32'(n), 32'd64);
        lookup(32'h0C, 1'b0);

        // 2. training
        update(32'h0C, 1'b1, 1'b0);
        update(32'h0C, 1'b1, 1'b0);
        lookup(32'h0C, 1'b1);
        lookup(32'h10, 1'b0);

        // 3. saturation: ST stays ST, then step down
        update(32'h0C, 1'b1, 1'b0);
        update(32'h0C, 1'b1, 1'b0);
        update(32'h0C, 1'b1, 1'b0);
        update(32'h0C, 1'b0, 1'b0);
        lookup(32'h0C, 1'b1);
        tick();
        tick();
        check("hold_ptaken", 32'(predict_taken), 32'd1);
        check("hold_pvalid", 32'(predict_valid), 32'd0);
        update(32'h0C, 1'b0, 1'b0);
        lookup(32'h0C, 1'b0);

        // 4. aliasing and write-first bypass
        update(32'h0C, 1'b1, 1'b0);
        update(32'h0C, 1'b1, 1'b0);
        lookup(32'h10C, 1'b1);
        update(32'h0C, 1'b0, 1'b0);
        update(32'h0C, 1'b0, 1'b0);
        lookup(32'h0C, 1'b0);
        update_valid   = 1'b1;
        update_pc      = 32'h0C;
        update_taken   = 1'b1;
        lookup(32'h0C, 1'b1);
        update_valid   = 1'b0;
        lookup(32'h0C, 1'b1);
        drain();

        // 5. clear sweep; updates during it are dropped
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_ready_low", 32'(ready), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        update(32'h0C, 1'b1, 1'b1);
        update(32'h0C, 1'b1, 1'b1);
        lookup(32'h0C, 1'b0);
        wait_ready(n);
        check("clr_cycles", 32'(n + 13), 32'd64);
        lookup(32'h0C, 1'b0);
        lookup(32'h10C, 1'b0);
        drain();

        // 6. stats, gated by ready, cleared by reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        update(32'h40, 1'b1, 1'b1);
        wait_ready(n);
        check("rst2_cycles", 32'(n + 1), 32'd64);
        update(32'h40, 1'b1, 1'b1);
        update(32'h40, 1'b0, 1'b0);
        update(32'h44, 1'b1, 1'b1);
        update(32'h48, 1'b0, 1'b0);
        update(32'h40, 1'b1, 1'b0);
`ifdef BHT_STATS_EN
        exp_u = 32'd5;
        exp_m = 32'd2;
`else
        exp_u = 32'd0;
        exp_m = 32'd0;
`endif
        check("stat_updates", stat_updates, exp_u);
        check("stat_mispreds", stat_mispreds, exp_m);
        update(32'h40, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_upd", stat_updates, 32'd0);
        check("midrst_mis", stat_mispreds, 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_pvalid", 32'(predict_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        wait_ready(n);
        check("rst3_cycles", 32'(n), 32'd64);
        lookup(32'h40, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
